sub16_pipe: RTL and testbench
=============================

# sub16_pipe

Pipelined 16-bit subtractor computing y = a − b − Bin with borrow-out Bo, the inverse operation of the team's hierarchical ripple-carry adder_16bit. It processes the operands in four 4-bit slices, one slice per register stage, and the borrow ripples from stage to stage. Both sides use a valid/ready handshake, so the block sits between a producer and a consumer in the datapath and sustains one result per cycle under backpressure.

## Interface
- No parameters; width fixed at 16 bits, 4 stages × 4 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  16  minuend, unsigned.
- b  in  16  subtrahend, unsigned.
- Bin  in  1  borrow-in.
- in_valid  in  1  a/b/Bin valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- y  out  16  difference, (a − b − Bin) mod 2^16.
- Bo  out  1  borrow-out; 1 iff a < b + Bin (unsigned, 17-bit compare).
- out_valid  out  1  y/Bo valid.
- out_ready  in  1  consumer accepts y/Bo this cycle.

## Operation
- Stages S0..S3, each with a valid bit vK.
  - SK computes result bits [4K+3:4K] from its operand slice and the borrow registered by S(K−1). S0 uses Bin.
  - SK forwards the upper operand bits, all lower result bits and its borrow-out.
  - S3 holds the complete y and Bo, which drive the outputs directly; out_valid = v3.
- Slice arithmetic: {borrow, d[3:0]} = {1'b0, a_s} − {1'b0, b_s} − borrow_in, evaluated in 5 bits; borrow = bit 4.
- Advance rule: adv3 = v3 & out_ready. SK may load when ~vK or adv(K+1). in_ready = (~v0 | adv1) & ~rst.
  - The ready chain is combinational from out_ready to in_ready.
- Accept happens when in_valid & in_ready. Un-accepted inputs are ignored, not latched.
- Bubbles: a stage that loads from an empty predecessor clears its valid bit. Bubbles do not block upstream stages.
- Stall: while v3 & ~out_ready, y and Bo hold bit-stable. Upstream stages fill any empty slots and then hold.
- Ordering: results leave strictly in acceptance order. No drop, no duplicate.
- Simultaneous accept and output: when every stage is full and out_ready = 1, the block accepts a new input and emits a result in the same cycle, so throughput is 1/cycle.

## Timing
- Reset, synchronous: on a rising edge with rst = 1, all vK are cleared and all data and borrow registers are zeroed.
  - After that edge: y = 0x0000, Bo = 0, out_valid = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after rst drops.
- Reset mid-operation: every in-flight transaction is discarded. No result for it is ever presented after reset.
- Latency: a transaction accepted at edge E loads S0 at E. With no stall, it reaches S3 at E+3, and out_valid rises in the cycle following E+3.
  - Stalls add latency one cycle at a time.
- Throughput: one accept and one output per cycle when out_ready is held at 1.
- Outputs are registered except in_ready, which is combinational.

## Test plan
- Basic case: a=0x1234, b=0x0234, Bin=0 → y=0x1000, Bo=0. out_valid rises 4 cycles after the accept cycle.
- Borrow through all stages: a=0x1000, b=0x0001, Bin=0 → y=0x0FFF, Bo=0. Also a=0x0000, b=0x0001, Bin=0 → y=0xFFFF, Bo=1.
- Bin corners: a=0xFFFF, b=0xFFFF, Bin=1 → y=0xFFFF, Bo=1. Also a=0x8000, b=0x7FFF, Bin=1 → y=0x0000, Bo=0.
- Streaming: 64 random back-to-back transactions with out_ready=1 → one result per cycle, in order, all matching the reference model {Bo,y} = {1'b0,a} − {1'b0,b} − Bin.
- Backpressure: random in_valid and random out_ready over 1000 transactions → no loss or duplication; y/Bo stable while out_valid & ~out_ready; in_ready=0 only when all 4 stages are full and out_ready=0.
- Reset mid-flight: accept 3 transactions, then assert rst for 1 cycle → out_valid=0, y=0x0000, Bo=0, no stale result afterwards. The next accepted transaction appears with latency 4.

Source files
------------

// File: rtl/sub16_if.sv
// sub16_if: operand/result bundle for the pipelined 16-bit subtractor.
//   a, b      : 16-bit unsigned minuend / subtrahend
//   Bin       : borrow-in
//   in_valid  : producer offers a/b/Bin this cycle
//   in_ready  : subtractor takes the offered operands this cycle
//   y, Bo     : difference and borrow-out
//   out_valid : y/Bo hold a result
//   out_ready : consumer takes y/Bo this cycle
// master = producer/consumer side, slave = subtractor side.
interface sub16_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        Bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic        Bo;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, Bin, in_valid, out_ready,
        input  in_ready, y, Bo, out_valid
    );

    modport slave (
        input  a, b, Bin, in_valid, out_ready,
        output in_ready, y, Bo, out_valid
    );
endinterface

// File: rtl/sub16_pipe.sv
// sub16_pipe: four-stage pipelined 16-bit subtractor, y = a - b - Bin with
// borrow-out Bo. Each stage resolves one 4-bit slice and hands its borrow to
// the next stage, so the borrow ripples one slice per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears valids and all data)
//   bus : sub16_if.slave -- a, b, Bin, in_valid, in_ready (comb),
//         y, Bo, out_valid (registered), out_ready
module sub16_pipe (
    input  logic     clk,
    input  logic     rst,
    sub16_if.slave   bus
);

    // Stage registers: remaining operand bits, finished result bits, borrow.
    logic        vld_p0, vld_p1, vld_p2, vld_p3;
    logic [15:4] a_p0, b_p0;
    logic [3:0]  d_p0;
    logic        bo_p0;
    logic [15:8] a_p1, b_p1;
    logic [7:0]  d_p1;
    logic        bo_p1;
    logic [15:12] a_p2, b_p2;
    logic [11:0] d_p2;
    logic        bo_p2;
    logic [15:0] d_p3;
    logic        bo_p3;

    logic        ld_p0, ld_p1, ld_p2, ld_p3;
    logic        acc;
    logic [4:0]  s0, s1, s2, s3;

    // 5-bit slice subtract; bit 4 is the borrow-out (wraps negative).
    function automatic logic [4:0] sub_slice(
        input logic [3:0] x,
        input logic [3:0] z,
        input logic       bi
    );
        sub_slice = {1'b0, x} - {1'b0, z} - {4'b0000, bi};
    endfunction

    // A stage may take new contents when empty or when its occupant moves on.
    // The chain is purely combinational from out_ready back to in_ready.
    assign ld_p3 = ~vld_p3 | bus.out_ready;
    assign ld_p2 = ~vld_p2 | ld_p3;
    assign ld_p1 = ~vld_p1 | ld_p2;
    assign ld_p0 = ~vld_p0 | ld_p1;

    assign bus.in_ready = ld_p0 & ~rst;
    assign acc          = bus.in_valid & bus.in_ready;

    assign s0 = sub_slice(bus.a[3:0], bus.b[3:0], bus.Bin);
    assign s1 = sub_slice(a_p0[7:4], b_p0[7:4], bo_p0);
    assign s2 = sub_slice(a_p1[11:8], b_p1[11:8], bo_p1);
    assign s3 = sub_slice(a_p2, b_p2, bo_p2);

    assign bus.y         = d_p3;
    assign bus.Bo        = bo_p3;
    assign bus.out_valid = vld_p3;

    // Valid bits: a loading stage copies its predecessor's valid, so an
    // empty predecessor turns into a bubble here.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (ld_p0) vld_p0 <= acc;
            if (ld_p1) vld_p1 <= vld_p0;
            if (ld_p2) vld_p2 <= vld_p1;
            if (ld_p3) vld_p3 <= vld_p2;
        end
    end

    // Data only moves when real data arrives, so a stalled S3 stays
    // bit-stable and bubbles never disturb held contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p0 <= '0; b_p0 <= '0; d_p0 <= '0; bo_p0 <= 1'b0;
            a_p1 <= '0; b_p1 <= '0; d_p1 <= '0; bo_p1 <= 1'b0;
            a_p2 <= '0; b_p2 <= '0; d_p2 <= '0; bo_p2 <= 1'b0;
            d_p3 <= '0; bo_p3 <= 1'b0;
        end else begin
            // S0: bits [3:0]
            if (acc) begin
                a_p0  <= bus.a[15:4];
                b_p0  <= bus.b[15:4];
                d_p0  <= s0[3:0];
                bo_p0 <= s0[4];
            end
            // S1: bits [7:4]
            if (ld_p1 && vld_p0) begin
                a_p1  <= a_p0[15:8];
                b_p1  <= b_p0[15:8];
                d_p1  <= {s1[3:0], d_p0};
                bo_p1 <= s1[4];
            end
            // S2: bits [11:8]
            if (ld_p2 && vld_p1) begin
                a_p2  <= a_p1[15:12];
                b_p2  <= b_p1[15:12];
                d_p2  <= {s2[3:0], d_p1};
                bo_p2 <= s2[4];
            end
            // S3: bits [15:12], final borrow
            if (ld_p3 && vld_p2) begin
                d_p3  <= {s3[3:0], d_p2};
                bo_p3 <= s3[4];
            end
        end
    end

endmodule

// File: tb/tb_sub16_pipe.sv
// tb_sub16_pipe: self-checking bench for sub16_pipe. Directed corner vectors,
// back-to-back streaming, random backpressure and mid-flight reset, checked
// against a queue-based model using plain 17-bit arithmetic.
module tb_sub16_pipe;

    logic clk;
    logic rst;
    sub16_if bif ();

    sub16_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] z, input logic bi);
        ref_sub = {1'b0, x} - {1'b0, z} - {16'd0, bi};
    endfunction

    // One isolated transaction with out_ready held high; returns the result
    // and the number of edges from the accept edge (counted as 1) until
    // out_valid is seen.
    task automatic single_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                              output logic [15:0] oy, output logic obo, output int lat);
        bif.a = ta; bif.b = tb_v; bif.Bin = tbin;
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        lat = 1;
        while (!bif.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        oy = bif.y; obo = bif.Bo;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.in_valid = 1'b0; bif.out_ready = 1'b0;
        bif.a = '0; bif.b = '0; bif.Bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", bif.out_valid); end
        n_cmp++; if (bif.y !== 16'h0000) begin n_err++; $display("FAIL reset_y got=%h want=0000", bif.y); end
        n_cmp++; if (bif.Bo !== 1'b0) begin n_err++; $display("FAIL reset_Bo got=%b want=0", bif.Bo); end
        @(negedge clk);
        n_cmp++; if (bif.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_hi got=%b want=0", bif.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_lo got=%b want=1", bif.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] oy; logic obo; int lat;
        single_txn(16'h1234, 16'h0234, 1'b0, oy, obo, lat);
        n_cmp++; if (oy !== 16'h1000) begin n_err++; $display("FAIL basic_y got=%h want=1000", oy); end
        n_cmp++; if (obo !== 1'b0) begin n_err++; $display("FAIL basic_Bo got=%b want=0", obo); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL basic_latency got=%0d want=4", lat); end
    endtask

    task automatic test_borrow_chain();
        logic [15:0] oy; logic obo; int lat;
        single_txn(16'h1000, 16'h0001, 1'b0, oy, obo, lat);
        n_cmp++; if (oy !== 16'h0FFF || obo !== 1'b0) begin n_err++; $display("FAIL borrow_1000 got=%b_%h want=0_0fff", obo, oy); end
        single_txn(16'h0000, 16'h0001, 1'b0, oy, obo, lat);
        n_cmp++; if (oy !== 16'hFFFF || obo !== 1'b1) begin n_err++; $display("FAIL borrow_0000 got=%b_%h want=1_ffff", obo, oy); end
    endtask

    task automatic test_bin_corners();
        logic [15:0] oy; logic obo; int lat;
        single_txn(16'hFFFF, 16'hFFFF, 1'b1, oy, obo, lat);
        n_cmp++; if (oy !== 16'hFFFF || obo !== 1'b1) begin n_err++; $display("FAIL bin_ffff got=%b_%h want=1_ffff", obo, oy); end
        single_txn(16'h8000, 16'h7FFF, 1'b1, oy, obo, lat);
        n_cmp++; if (oy !== 16'h0000 || obo !== 1'b0) begin n_err++; $display("FAIL bin_8000 got=%b_%h want=0_0000", obo, oy); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rcvd = 0, cyc = 0, first_out = -1, last_out = -1;
        logic [16:0] e;
        exp_q.delete();
        bif.out_ready = 1'b1;
        while ((sent < 64 || rcvd < sent) && cyc < 200) begin
            if (sent < 64) begin
                bif.in_valid = 1'b1;
                bif.a = 16'($urandom); bif.b = 16'($urandom); bif.Bin = 1'($urandom);
            end else begin
                bif.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bif.in_valid) begin
                n_cmp++; if (bif.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready cyc=%0d got=%b want=1", cyc, bif.in_ready); end
                if (bif.in_ready) begin exp_q.push_back(ref_sub(bif.a, bif.b, bif.Bin)); sent++; end
            end
            if (bif.out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra got=%b_%h want=none", bif.Bo, bif.y);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.Bo, bif.y} !== e) begin n_err++; $display("FAIL stream_data idx=%0d got=%h want=%h", rcvd, {bif.Bo, bif.y}, e); end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                rcvd++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bif.in_valid = 1'b0;
        n_cmp++; if (rcvd != 64) begin n_err++; $display("FAIL stream_count got=%0d want=64", rcvd); end
        n_cmp++; if (last_out - first_out != 63) begin n_err++; $display("FAIL stream_rate span got=%0d want=63", last_out - first_out); end
    endtask

    task automatic test_backpressure();
        int sent = 0, rcvd = 0, cyc = 0;
        logic stall_prev = 1'b0;
        logic [15:0] py = '0;
        logic pbo = 1'b0;
        logic exp_rdy;
        logic [16:0] e;
        exp_q.delete();
        while ((sent < 1000 || rcvd < sent) && cyc < 20000) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                bif.in_valid = 1'b1;
                bif.a = 16'($urandom); bif.b = 16'($urandom); bif.Bin = 1'($urandom);
            end else begin
                bif.in_valid = 1'b0;
            end
            bif.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            // Four in flight can only mean every stage is occupied.
            exp_rdy = !(exp_q.size() == 4 && !bif.out_ready);
            n_cmp++; if (bif.in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, bif.in_ready, exp_rdy); end
            if (stall_prev) begin
                n_cmp++;
                if (bif.out_valid !== 1'b1 || bif.y !== py || bif.Bo !== pbo) begin
                    n_err++; $display("FAIL bp_stall_hold cyc=%0d got=%b_%b_%h want=1_%b_%h", cyc, bif.out_valid, bif.Bo, bif.y, pbo, py);
                end
            end
            if (bif.in_valid && bif.in_ready) begin exp_q.push_back(ref_sub(bif.a, bif.b, bif.Bin)); sent++; end
            if (bif.out_valid && bif.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_duplicate got=%b_%h want=none", bif.Bo, bif.y);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.Bo, bif.y} !== e) begin n_err++; $display("FAIL bp_data idx=%0d got=%h want=%h", rcvd, {bif.Bo, bif.y}, e); end
                end
                rcvd++;
            end
            stall_prev = bif.out_valid & ~bif.out_ready;
            py = bif.y; pbo = bif.Bo;
            @(posedge clk); #1;
            cyc++;
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        n_cmp++; if (rcvd != 1000) begin n_err++; $display("FAIL bp_count got=%0d want=1000", rcvd); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        logic [15:0] oy; logic obo; int lat;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.in_valid = 1'b1;
            bif.a = 16'($urandom); bif.b = 16'($urandom); bif.Bin = 1'($urandom);
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid got=%b want=0", bif.out_valid); end
        n_cmp++; if (bif.y !== 16'h0000 || bif.Bo !== 1'b0) begin n_err++; $display("FAIL mid_rst_data got=%b_%h want=0_0000", bif.Bo, bif.y); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bif.out_valid) stale++;
            @(posedge clk); #1;
        end
        n_cmp++; if (stale != 0) begin n_err++; $display("FAIL mid_rst_stale got=%0d want=0", stale); end
        single_txn(16'h00FF, 16'h0100, 1'b0, oy, obo, lat);
        n_cmp++; if (oy !== 16'hFFFF || obo !== 1'b1) begin n_err++; $display("FAIL mid_rst_next got=%b_%h want=1_ffff", obo, oy); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL mid_rst_latency got=%0d want=4", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_chain();
        test_bin_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
